dma_sd: RTL and testbench

- DMA controller that reads one 512-byte SD card data block over the shared SD SPI byte interface and writes it into Z80 memory without CPU involvement.
- Programmed through the common DMA register bus from the port decoder at ports $1C-$1F, when DMA module 2 is selected.
- Owns the SPI byte engine only while busy.
- Requests the memory bus from the memory arbiter one byte at a time.

---
 rtl/dma_sd.sv | 254 +++++++++++++++++++++++++
 tb/tb_dma_sd.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sd.sv
// ---------------------------------------------------------------------------
// dma_sd
//
// Reads one data block from an SD card through the shared SPI byte engine
// and writes it byte-by-byte into Z80 memory via the memory arbiter, with no
// CPU involvement.
//
// Sequence per transfer:
//   poll SPI bytes for the 0xFE start token (bounded by TOKEN_TIMEOUT),
//   then for each of BLOCK_LEN bytes: one SPI exchange followed by one
//   memory write request, then two CRC exchanges that are discarded.
//
// Ports:
//   cpu_clock, rst          clock and synchronous active-high reset
//   dma_select, dma_wrstb   register write qualifier / one-cycle strobe
//   dma_regsel, dma_din     register select (HAD/MAD/LAD/CST) and data
//   dma_dout                register read data (combinational)
//   spi_start, spi_din      exchange start pulse and transmit byte (0xFF)
//   spi_dout, spi_rdy       received byte and engine-idle flag
//   spi_own                 high while this block owns the SPI engine
//   dma_req, dma_ack        memory write request / one-cycle grant
//   dma_addr, dma_wd        memory byte address and write data
// ---------------------------------------------------------------------------
module dma_sd #(
    parameter int BLOCK_LEN     = 512,
    parameter int TOKEN_TIMEOUT = 4095
) (
    input  logic        cpu_clock,
    input  logic        rst,
    input  logic        dma_select,
    input  logic        dma_wrstb,
    input  logic [1:0]  dma_regsel,
    input  logic [7:0]  dma_din,
    output logic [7:0]  dma_dout,
    output logic        spi_start,
    output logic [7:0]  spi_din,
    input  logic [7:0]  spi_dout,
    input  logic        spi_rdy,
    output logic        spi_own,
    output logic        dma_req,
    input  logic        dma_ack,
    output logic [21:0] dma_addr,
    output logic [7:0]  dma_wd
);

    localparam int CNT_W  = $clog2(BLOCK_LEN + 1);
    localparam int POLL_W = $clog2(TOKEN_TIMEOUT + 1);

    localparam logic [1:0] REG_HAD = 2'd0;
    localparam logic [1:0] REG_MAD = 2'd1;
    localparam logic [1:0] REG_LAD = 2'd2;
    localparam logic [1:0] REG_CST = 2'd3;

    localparam logic [7:0] START_TOKEN = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOKEN,   // issue a token-poll exchange
        S_TWAIT,   // wait for the token-poll byte
        S_DATA,    // issue a data exchange
        S_DWAIT,   // wait for the data byte
        S_MEM,     // memory write outstanding
        S_CRC,     // issue a CRC exchange
        S_CWAIT    // wait for the CRC byte
    } state_t;

    state_t            state_reg;
    logic [21:0]       addr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [POLL_W-1:0] poll_reg;
    logic              crc_second_reg;
    logic              err_reg;
    logic              done_reg;
    logic              abort_reg;
    logic              spi_start_reg;
    logic              dma_req_reg;
    logic [7:0]        dma_wd_reg;

    logic busy;
    logic reg_wr;
    logic cst_wr;
    logic spi_done;

    assign busy   = (state_reg != S_IDLE);
    assign reg_wr = dma_select && dma_wrstb;
    assign cst_wr = reg_wr && (dma_regsel == REG_CST);

    // spi_rdy still shows the pre-exchange idle level during the start
    // pulse cycle, so it only counts as completion once the pulse is gone.
    assign spi_done = spi_rdy && !spi_start_reg;

    assign spi_start = spi_start_reg;
    assign spi_din   = 8'hFF;
    assign spi_own   = busy;
    assign dma_req   = dma_req_reg;
    assign dma_addr  = addr_reg;
    assign dma_wd    = dma_wd_reg;

    always_comb begin
        dma_dout = 8'h00;
        case (dma_regsel)
            REG_HAD: dma_dout = {2'b00, addr_reg[21:16]};
            REG_MAD: dma_dout = addr_reg[15:8];
            REG_LAD: dma_dout = addr_reg[7:0];
            REG_CST: dma_dout = {busy, err_reg, done_reg, 5'b00000};
            default: dma_dout = 8'h00;
        endcase
    end

    always_ff @(posedge cpu_clock) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            count_reg      <= '0;
            poll_reg       <= '0;
            crc_second_reg <= 1'b0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
            abort_reg      <= 1'b0;
            spi_start_reg  <= 1'b0;
            dma_req_reg    <= 1'b0;
            dma_wd_reg     <= '0;
        end else begin
            spi_start_reg <= 1'b0;

            // Abort is only latched here; the FSM acts on it at the next
            // point where it would otherwise start an exchange or finish a
            // memory write, so no SPI exchange or memory cycle is cut short.
            if (cst_wr && busy && dma_din[6]) begin
                abort_reg <= 1'b1;
            end

            // Address registers are frozen for the duration of a transfer.
            if (reg_wr && !busy) begin
                case (dma_regsel)
                    REG_HAD: addr_reg[21:16] <= dma_din[5:0];
                    REG_MAD: addr_reg[15:8]  <= dma_din;
                    REG_LAD: addr_reg[7:0]   <= dma_din;
                    default: ;
                endcase
            end

            case (state_reg)
                S_IDLE: begin
                    if (cst_wr && dma_din[7]) begin
                        err_reg        <= 1'b0;
                        done_reg       <= 1'b0;
                        abort_reg      <= 1'b0;
                        count_reg      <= CNT_W'(BLOCK_LEN);
                        poll_reg       <= '0;
                        crc_second_reg <= 1'b0;
                        state_reg      <= S_TOKEN;
                    end
                end

                S_TOKEN: begin
                    if (abort_reg) begin
                        abort_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (spi_rdy) begin
                        spi_start_reg <= 1'b1;
                        state_reg     <= S_TWAIT;
                    end
                end

                S_TWAIT: begin
                    if (spi_done) begin
                        if (spi_dout == START_TOKEN) begin
                            state_reg <= S_DATA;
                        end else if (poll_reg == POLL_W'(TOKEN_TIMEOUT - 1)) begin
                            // Card never produced a start token.
                            err_reg   <= 1'b1;
                            abort_reg <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            poll_reg  <= poll_reg + 1'b1;
                            state_reg <= S_TOKEN;
                        end
                    end
                end

                S_DATA: begin
                    if (abort_reg) begin
                        abort_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (spi_rdy) begin
                        spi_start_reg <= 1'b1;
                        state_reg     <= S_DWAIT;
                    end
                end

                S_DWAIT: begin
                    if (spi_done) begin
                        dma_wd_reg  <= spi_dout;
                        dma_req_reg <= 1'b1;
                        state_reg   <= S_MEM;
                    end
                end

                S_MEM: begin
                    // Request, address and data stay put until the grant;
                    // the next exchange only starts after the write lands.
                    if (dma_ack && dma_req_reg) begin
                        dma_req_reg <= 1'b0;
                        addr_reg    <= addr_reg + 22'd1;
                        count_reg   <= count_reg - 1'b1;
                        if (abort_reg) begin
                            abort_reg <= 1'b0;
                            err_reg   <= 1'b0;
                            done_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end else if (count_reg == CNT_W'(1)) begin
                            state_reg <= S_CRC;
                        end else begin
                            state_reg <= S_DATA;
                        end
                    end
                end

                S_CRC: begin
                    if (abort_reg) begin
                        abort_reg <= 1'b0;
                        err_reg   <= 1'b0;
                        done_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else if (spi_rdy) begin
                        spi_start_reg <= 1'b1;
                        state_reg     <= S_CWAIT;
                    end
                end

                S_CWAIT: begin
                    if (spi_done) begin
                        if (crc_second_reg) begin
                            done_reg  <= 1'b1;
                            abort_reg <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            crc_second_reg <= 1'b1;
                            state_reg      <= S_CRC;
                        end
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_sd.sv
module tb_dma_sd;

    logic        cpu_clock = 1'b0;
    logic        rst = 1'b1;
    logic        dma_select = 1'b0;
    logic        dma_wrstb = 1'b0;
    logic [1:0]  dma_regsel = 2'd0;
    logic [7:0]  dma_din = 8'h00;
    logic [7:0]  dma_dout;
    logic        spi_start;
    logic [7:0]  spi_din;
    logic [7:0]  spi_dout = 8'hFF;
    logic        spi_rdy = 1'b1;
    logic        spi_own;
    logic        dma_req;
    logic        dma_ack = 1'b0;
    logic [21:0] dma_addr;
    logic [7:0]  dma_wd;

    dma_sd dut (
        .cpu_clock  (cpu_clock),
        .rst        (rst),
        .dma_select (dma_select),
        .dma_wrstb  (dma_wrstb),
        .dma_regsel (dma_regsel),
        .dma_din    (dma_din),
        .dma_dout   (dma_dout),
        .spi_start  (spi_start),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout),
        .spi_rdy    (spi_rdy),
        .spi_own    (spi_own),
        .dma_req    (dma_req),
        .dma_ack    (dma_ack),
        .dma_addr   (dma_addr),
        .dma_wd     (dma_wd)
    );

    always #5 cpu_clock = ~cpu_clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- SD card / SPI engine model ----------------
    // Byte stream of a card answering a block read, by exchange index.
    int spi_pattern = 0;   // 0: 3x FF, FE, 512 data bytes, AA 55; 1: always FF
    int xfer_base   = 0;
    int spi_xfers   = 0;
    int spi_busy    = 0;
    int viol_spi    = 0;
    logic [7:0] spi_pend = 8'hFF;

    function automatic logic [7:0] card_byte(input int pat, input int k);
        if (pat == 1) return 8'hFF;
        if (k < 3) return 8'hFF;
        if (k == 3) return 8'hFE;
        if (k < 516) return 8'((k - 4) % 256);
        if (k == 516) return 8'hAA;
        if (k == 517) return 8'h55;
        return 8'hFF;
    endfunction

    always @(negedge cpu_clock) begin
        if (spi_start) begin
            if (!(spi_rdy && spi_own)) viol_spi++;
            if (dma_req) viol_spi++;
        end
        if (spi_busy > 0) begin
            spi_busy--;
            if (spi_busy == 0) begin
                spi_dout = spi_pend;
                spi_rdy  = 1'b1;
            end
        end else if (spi_start && spi_rdy) begin
            spi_pend = card_byte(spi_pattern, spi_xfers - xfer_base);
            spi_xfers++;
            spi_rdy  = 1'b0;
            spi_busy = 2;
        end
    end

    // ---------------- memory arbiter model ----------------
    logic [21:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          ack_max  = 0;
    logic        ack_hold = 1'b0;
    logic        in_req   = 1'b0;
    int          ack_wait = 0;
    int          req_seen = 0;
    int          viol_mem = 0;
    logic [21:0] cap_addr = '0;
    logic [7:0]  cap_wd = '0;

    always @(negedge cpu_clock) begin
        if (dma_ack) begin
            dma_ack = 1'b0;
        end else if (!dma_req) begin
            in_req = 1'b0;
        end else begin
            if (!in_req) begin
                in_req   = 1'b1;
                ack_wait = int'($urandom_range(0, ack_max));
                cap_addr = dma_addr;
                cap_wd   = dma_wd;
                req_seen++;
            end
            if (dma_addr !== cap_addr || dma_wd !== cap_wd) viol_mem++;
            if (!ack_hold) begin
                if (ack_wait == 0) begin
                    dma_ack = 1'b1;
                    in_req  = 1'b0;
                    got_addr.push_back(dma_addr);
                    got_data.push_back(dma_wd);
                end else begin
                    ack_wait--;
                end
            end
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wr(input logic sel, input logic [1:0] r, input logic [7:0] d);
        @(negedge cpu_clock);
        dma_select = sel;
        dma_regsel = r;
        dma_din    = d;
        dma_wrstb  = 1'b1;
        @(negedge cpu_clock);
        dma_wrstb  = 1'b0;
        dma_select = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [7:0] v);
        @(negedge cpu_clock);
        dma_regsel = r;
        #1 v = dma_dout;
    endtask

    task automatic read_addr(output logic [21:0] a, output logic [7:0] had);
        logic [7:0] h, m, l;
        rd(2'd0, h);
        rd(2'd1, m);
        rd(2'd2, l);
        had = h;
        a   = {h[5:0], m, l};
    endtask

    task automatic set_addr(input logic [21:0] a);
        wr(1'b1, 2'd0, {2'b00, a[21:16]});
        wr(1'b1, 2'd1, a[15:8]);
        wr(1'b1, 2'd2, a[7:0]);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (spi_own && n < budget) begin
            @(negedge cpu_clock);
            n++;
        end
        check({name, "_finished"}, 32'(n < budget), 32'd1);
    endtask

    // Expected image of a block: byte i at base+i (22-bit wrap), value i mod 256.
    task automatic check_block(input logic [21:0] base, input int first, input int n, input string name);
        int nbad = 0;
        for (int i = 0; i < n; i++) begin
            if (got_addr[first + i] !== 22'(base + 22'(i)) || got_data[first + i] !== 8'(i))
                nbad++;
        end
        check({name, "_data"}, 32'(nbad), 32'd0);
    endtask

    task automatic run_block(input logic [21:0] base, input int maxd, input string name);
        int wr_base;
        logic [7:0] cst;
        ack_max = maxd;
        set_addr(base);
        spi_pattern = 0;
        xfer_base   = spi_xfers;
        wr_base     = got_addr.size();
        wr(1'b1, 2'd3, 8'h80);
        wait_idle(30000, name);
        check({name, "_nwrites"}, 32'(got_addr.size() - wr_base), 32'd512);
        if (got_addr.size() - wr_base >= 512) check_block(base, wr_base, 512, name);
        check({name, "_xfers"}, 32'(spi_xfers - xfer_base), 32'd518);
        rd(2'd3, cst);
        check({name, "_cst"}, 32'(cst), 32'h20);
        check({name, "_spi_own"}, 32'(spi_own), 32'd0);
        $display("block %s base=0x%06h writes=%0d xfers=%0d cst=0x%02h",
                 name, base, got_addr.size() - wr_base, spi_xfers - xfer_base, cst);
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  r;
        logic [7:0]  d;
        logic [21:0] exp;
    } reg_vec_t;

    reg_vec_t vec[6];

    initial begin
        logic [21:0] a, model_addr;
        logic [7:0]  h, v;
        int          n, wr_base, base_req;

        vec[0] = '{1'b1, 2'd0, 8'h3F, 22'h3F0000};
        vec[1] = '{1'b1, 2'd1, 8'h12, 22'h3F1200};
        vec[2] = '{1'b1, 2'd2, 8'h34, 22'h3F1234};
        vec[3] = '{1'b0, 2'd2, 8'h99, 22'h3F1234};
        vec[4] = '{1'b0, 2'd0, 8'h01, 22'h3F1234};
        vec[5] = '{1'b1, 2'd0, 8'hC5, 22'h051234};

        // ---- reset state ----
        repeat (3) @(negedge cpu_clock);
        rst = 1'b0;
        @(negedge cpu_clock);
        check("rst_dma_req", 32'(dma_req), 32'd0);
        check("rst_spi_own", 32'(spi_own), 32'd0);
        check("rst_spi_start", 32'(spi_start), 32'd0);
        check("rst_dma_addr", 32'(dma_addr), 32'd0);
        check("rst_dma_wd", 32'(dma_wd), 32'd0);
        check("spi_din", 32'(spi_din), 32'hFF);
        rd(2'd3, v);
        check("rst_cst", 32'(v), 32'd0);

        // ---- table-driven register writes ----
        foreach (vec[i]) begin
            wr(vec[i].sel, vec[i].r, vec[i].d);
            read_addr(a, h);
            check($sformatf("regvec%0d_addr", i), 32'(a), 32'(vec[i].exp));
            check($sformatf("regvec%0d_had", i), 32'(h), 32'({2'b00, vec[i].exp[21:16]}));
            $display("regwr sel=%0d reg=%0d din=0x%02h -> addr=0x%06h", vec[i].sel, vec[i].r, vec[i].d, a);
        end

        // ---- randomized register writes against a byte-lane model ----
        model_addr = 22'h051234;
        for (int i = 0; i < 16; i++) begin
            logic       s;
            logic [1:0] r;
            logic [7:0] d;
            s = 1'($urandom);
            r = 2'($urandom_range(0, 2));
            d = 8'($urandom);
            wr(s, r, d);
            if (s) begin
                if (r == 2'd0) model_addr[21:16] = d[5:0];
                else if (r == 2'd1) model_addr[15:8] = d;
                else model_addr[7:0] = d;
            end
            read_addr(a, h);
            check($sformatf("rand_reg%0d", i), 32'(a), 32'(model_addr));
            $display("randwr sel=%0d reg=%0d din=0x%02h -> addr=0x%06h", s, r, d, a);
        end

        // ---- nominal transfer, with writes during busy that must be ignored ----
        ack_max = 0;
        set_addr(22'h001000);
        spi_pattern = 0;
        xfer_base   = spi_xfers;
        wr_base     = got_addr.size();
        wr(1'b1, 2'd3, 8'h80);
        check("start_busy", 32'(spi_own), 32'd1);
        wr(1'b1, 2'd2, 8'h77);
        wr(1'b1, 2'd3, 8'h80);
        wait_idle(30000, "nominal");
        check("nominal_nwrites", 32'(got_addr.size() - wr_base), 32'd512);
        if (got_addr.size() - wr_base >= 512) check_block(22'h001000, wr_base, 512, "nominal");
        check("nominal_xfers", 32'(spi_xfers - xfer_base), 32'd518);
        rd(2'd3, v);
        check("nominal_cst", 32'(v), 32'h20);
        check("nominal_spi_own", 32'(spi_own), 32'd0);
        read_addr(a, h);
        check("nominal_end_addr", 32'(a), 32'h001200);
        $display("block nominal writes=%0d cst=0x%02h end_addr=0x%06h", got_addr.size() - wr_base, v, a);

        // ---- token timeout ----
        spi_pattern = 1;
        xfer_base   = spi_xfers;
        base_req    = req_seen;
        wr(1'b1, 2'd3, 8'h80);
        wait_idle(60000, "timeout");
        check("timeout_xfers", 32'(spi_xfers - xfer_base), 32'd4095);
        rd(2'd3, v);
        check("timeout_cst", 32'(v), 32'h40);
        check("timeout_no_req", 32'(req_seen - base_req), 32'd0);
        $display("block timeout xfers=%0d cst=0x%02h", spi_xfers - xfer_base, v);

        // ---- address wrap ----
        run_block(22'h3FFF00, 1, "wrap");
        read_addr(a, h);
        check("wrap_end_addr", 32'(a), 32'h000100);

        // ---- slow arbiter at a random base ----
        run_block(22'($urandom), 7, "slow");
        check("spi_rules", 32'(viol_spi), 32'd0);
        check("mem_stable", 32'(viol_mem), 32'd0);

        // ---- abort at byte 100 ----
        ack_max = 2;
        set_addr(22'h020000);
        spi_pattern = 0;
        xfer_base   = spi_xfers;
        wr_base     = got_addr.size();
        wr(1'b1, 2'd3, 8'h80);
        n = 0;
        while (got_addr.size() - wr_base < 100 && n < 20000) begin
            @(negedge cpu_clock);
            n++;
        end
        check("abort_reach100", 32'(n < 20000), 32'd1);
        wr(1'b1, 2'd3, 8'h40);
        wait_idle(2000, "abort");
        n = got_addr.size() - wr_base;
        check("abort_writes_le_101", 32'(n <= 101), 32'd1);
        check_block(22'h020000, wr_base, n, "abort");
        rd(2'd3, v);
        check("abort_cst", 32'(v), 32'h00);
        $display("block abort writes=%0d cst=0x%02h", n, v);

        // ---- reset while a memory write is outstanding ----
        ack_max = 0;
        set_addr(22'h100000);
        spi_pattern = 0;
        xfer_base   = spi_xfers;
        wr_base     = got_addr.size();
        wr(1'b1, 2'd3, 8'h80);
        n = 0;
        while (got_addr.size() - wr_base < 50 && n < 20000) begin
            @(negedge cpu_clock);
            n++;
        end
        ack_hold = 1'b1;
        n = 0;
        while (!dma_req && n < 200) begin
            @(negedge cpu_clock);
            n++;
        end
        repeat (2) @(negedge cpu_clock);
        check("rstmid_req_pending", 32'(dma_req), 32'd1);
        rst = 1'b1;
        @(negedge cpu_clock);
        check("rstmid_req_dropped", 32'(dma_req), 32'd0);
        check("rstmid_spi_own", 32'(spi_own), 32'd0);
        check("rstmid_dma_addr", 32'(dma_addr), 32'd0);
        check("rstmid_dma_wd", 32'(dma_wd), 32'd0);
        rst = 1'b0;
        ack_hold = 1'b0;
        read_addr(a, h);
        check("rstmid_addr_regs", 32'(a), 32'd0);
        rd(2'd3, v);
        check("rstmid_cst", 32'(v), 32'd0);
        $display("block reset_mid_mem writes_before=%0d addr=0x%06h cst=0x%02h", got_addr.size() - wr_base, a, v);

        check("spi_rules_final", 32'(viol_spi), 32'd0);
        check("mem_stable_final", 32'(viol_mem), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
